// File: rtl/squeeze_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// squeeze_ctrl_pkg
// Shared definitions for the squeeze kernel write path.
//   - Default widths for kernel RAM data/address and the repeat kernel counter.
//   - Write sequencer FSM state encoding.
// -----------------------------------------------------------------------------
package squeeze_ctrl_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_REP_LOAD = 2'd2,
    ST_DONE     = 2'd3
  } seq_state_t;

endpackage

// File: rtl/squeeze_pingpong_tracker.sv
// -----------------------------------------------------------------------------
// squeeze_pingpong_tracker
// Tracks which half of the two-kernel ping-pong RAM holds a loaded kernel.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   set_i          writer finished a kernel in half wr_half_o (flag must be clear)
//   release_i      consumer finished reading half rd_half_o
//   avail_o[1:0]   per-half "kernel loaded" flags
//   wr_half_o      half the writer fills next
//   rd_half_o      half the consumer reads next
// A release while the read half's flag is clear is ignored. A set and a
// release of different halves in the same cycle both take effect; the writer
// never sets a half whose flag is already set, so they never hit the same bit.
// -----------------------------------------------------------------------------
module squeeze_pingpong_tracker (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       set_i,
  input  logic       release_i,
  output logic [1:0] avail_o,
  output logic       wr_half_o,
  output logic       rd_half_o
);

  logic       rel_ok;
  logic [1:0] avail_nxt;

  always_comb begin
    rel_ok    = release_i & avail_o[rd_half_o];
    avail_nxt = avail_o;
    if (rel_ok) avail_nxt[rd_half_o] = 1'b0;
    if (set_i)  avail_nxt[wr_half_o] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avail_o   <= 2'b00;
      wr_half_o <= 1'b0;
      rd_half_o <= 1'b0;
    end else begin
      avail_o <= avail_nxt;
      if (set_i)  wr_half_o <= ~wr_half_o;
      if (rel_ok) rd_half_o <= ~rd_half_o;
    end
  end

endmodule

// File: rtl/squeeze_ker_wr_sequencer.sv
// -----------------------------------------------------------------------------
// squeeze_ker_wr_sequencer
// Streams squeeze-kernel weight words from the DDR loader into kernel RAM.
//   LOAD     : whole fire, addresses 0..fire limit, layer_end_o per kernel.
//   REP_LOAD : RAM used as a two-kernel ping-pong; addresses wrap at the pair
//              limit; writer stalls while the target half is still loaded.
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   start_i                       pulse in IDLE: latch config, begin fire
//   repeat_en_i, *_lim_i,
//   tot_rep_ker_i                 per-fire config (sampled on start only)
//   din_valid_i/din_i/din_ready_o loader word stream
//   ker_wr_en_o/addr_o/data_o     registered RAM write port
//   ker_avail_o, ker_release_i    ping-pong flags / consumer release
//   layer_end_o                   pulse with the last word of each kernel
//   busy_o, done_o                fire active / one-cycle completion
//   dbg_state_o                   current FSM state
//   stall_cnt_o                   present only with SQU_KER_WR_STALL_CNT_EN
// Handshake: a word transfers on a rising edge where din_valid_i and
// din_ready_o are both high; its RAM write appears on the outputs after that
// edge. din_ready_o depends only on registered state.
// Optional feature macro: SQU_KER_WR_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module squeeze_ker_wr_sequencer
  import squeeze_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              repeat_en_i,
  input  logic [ADDR_W-1:0] fire_addr_lim_i,
  input  logic [5:0]        layr_addr_lim_i,
  input  logic [6:0]        rep_addr_lim_i,
  input  logic [CNT_W-1:0]  tot_rep_ker_i,
  input  logic              din_valid_i,
  input  logic [DATA_W-1:0] din_i,
  output logic              din_ready_o,
  output logic              ker_wr_en_o,
  output logic [ADDR_W-1:0] ker_wr_addr_o,
  output logic [DATA_W-1:0] ker_wr_data_o,
  output logic [1:0]        ker_avail_o,
  input  logic              ker_release_i,
  output logic              layer_end_o,
`ifdef SQU_KER_WR_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        dbg_state_o
);

  seq_state_t        state;
  logic              wr_half;
  logic              rd_half;

  logic [ADDR_W-1:0] cfg_fire_lim;
  logic [5:0]        cfg_layr_lim;
  logic [6:0]        cfg_rep_lim;
  logic [CNT_W-1:0]  cfg_tot;

  logic [ADDR_W-1:0] wr_addr;
  logic [5:0]        lay_cnt;
  logic [CNT_W-1:0]  ker_cnt;

  logic              xfer;
  logic              ker_end;
  logic              fire_end;
  logic              pair_end;
  logic              rep_last;
  logic              set_half;

  always_comb begin
    din_ready_o = (state == ST_LOAD) |
                  ((state == ST_REP_LOAD) & ~ker_avail_o[wr_half]);
    xfer        = din_valid_i & din_ready_o;
    ker_end     = (lay_cnt == cfg_layr_lim);
    fire_end    = (wr_addr == cfg_fire_lim);
    pair_end    = (wr_addr == ADDR_W'(cfg_rep_lim));
    rep_last    = ((ker_cnt + CNT_W'(1)) == cfg_tot);
    set_half    = xfer & (state == ST_REP_LOAD) & ker_end;
  end

  assign dbg_state_o = state;

  // The RAM half written is implied by the address (upper half once past the
  // kernel limit); the tracker's wr_half follows the same kernel boundaries,
  // so it is the pointer used for stall decisions.
  squeeze_pingpong_tracker u_tracker (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (set_half),
    .release_i (ker_release_i),
    .avail_o   (ker_avail_o),
    .wr_half_o (wr_half),
    .rd_half_o (rd_half)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      cfg_fire_lim  <= '0;
      cfg_layr_lim  <= '0;
      cfg_rep_lim   <= '0;
      cfg_tot       <= '0;
      wr_addr       <= '0;
      lay_cnt       <= '0;
      ker_cnt       <= '0;
      ker_wr_en_o   <= 1'b0;
      ker_wr_addr_o <= '0;
      ker_wr_data_o <= '0;
      layer_end_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
    end else begin
      ker_wr_en_o <= xfer;
      layer_end_o <= xfer & ker_end;
      done_o      <= 1'b0;
      if (xfer) begin
        ker_wr_addr_o <= wr_addr;
        ker_wr_data_o <= din_i;
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cfg_fire_lim <= fire_addr_lim_i;
            cfg_layr_lim <= layr_addr_lim_i;
            cfg_rep_lim  <= rep_addr_lim_i;
            cfg_tot      <= tot_rep_ker_i;
            wr_addr      <= '0;
            lay_cnt      <= '0;
            ker_cnt      <= '0;
            busy_o       <= 1'b1;
            state        <= repeat_en_i ? ST_REP_LOAD : ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            lay_cnt <= ker_end ? 6'd0 : lay_cnt + 6'd1;
            if (fire_end) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
            end
          end
        end

        ST_REP_LOAD: begin
          if (xfer) begin
            lay_cnt <= ker_end ? 6'd0 : lay_cnt + 6'd1;
            wr_addr <= pair_end ? '0 : wr_addr + ADDR_W'(1);
            if (ker_end) begin
              ker_cnt <= ker_cnt + CNT_W'(1);
              if (rep_last) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                state  <= ST_DONE;
              end
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SQU_KER_WR_STALL_CNT_EN
  // Cycles the loader offered a word but the ping-pong was full; saturating.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((state == ST_IDLE) && start_i) begin
      stall_cnt_o <= '0;
    end else if ((state == ST_REP_LOAD) && din_valid_i && !din_ready_o &&
                 (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_squeeze_ker_wr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_squeeze_ker_wr_sequencer
// Table of fire configurations plus hand-written ping-pong / reset sequences.
// Expected write stream (address, data, layer_end) is built from the config
// and the words driven; the monitor logs every RAM write and done pulse.
// -----------------------------------------------------------------------------
module tb_squeeze_ker_wr_sequencer;
  import squeeze_ctrl_pkg::*;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int CW = 16;
  localparam int EW = 1 + AW + DW;

  typedef struct {
    logic        rep;
    logic [11:0] fire_lim;
    logic [5:0]  layr_lim;
    logic [6:0]  rep_lim;
    logic [15:0] tot;
    int          valid_pct;
    int          rel_delay;
    logic        glitch;
    int          exp_writes;
    int          exp_le;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_i = 1'b1;

  logic          start_i = 1'b0;
  logic          repeat_en_i = 1'b0;
  logic [AW-1:0] fire_addr_lim_i = '0;
  logic [5:0]    layr_addr_lim_i = '0;
  logic [6:0]    rep_addr_lim_i = '0;
  logic [CW-1:0] tot_rep_ker_i = '0;
  logic          din_valid_i = 1'b0;
  logic [DW-1:0] din_i = '0;
  logic          din_ready_o;
  logic          ker_wr_en_o;
  logic [AW-1:0] ker_wr_addr_o;
  logic [DW-1:0] ker_wr_data_o;
  logic [1:0]    ker_avail_o;
  logic          ker_release_i;
  logic          layer_end_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    dbg_state_o;
`ifdef SQU_KER_WR_STALL_CNT_EN
  logic [31:0]   stall_cnt_o;
`endif

  logic rel_auto = 1'b0;
  logic rel_man  = 1'b0;
  assign ker_release_i = rel_auto | rel_man;

  squeeze_ker_wr_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .repeat_en_i     (repeat_en_i),
    .fire_addr_lim_i (fire_addr_lim_i),
    .layr_addr_lim_i (layr_addr_lim_i),
    .rep_addr_lim_i  (rep_addr_lim_i),
    .tot_rep_ker_i   (tot_rep_ker_i),
    .din_valid_i     (din_valid_i),
    .din_i           (din_i),
    .din_ready_o     (din_ready_o),
    .ker_wr_en_o     (ker_wr_en_o),
    .ker_wr_addr_o   (ker_wr_addr_o),
    .ker_wr_data_o   (ker_wr_data_o),
    .ker_avail_o     (ker_avail_o),
    .ker_release_i   (ker_release_i),
    .layer_end_o     (layer_end_o),
`ifdef SQU_KER_WR_STALL_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
`endif
    .busy_o          (busy_o),
    .done_o          (done_o),
    .dbg_state_o     (dbg_state_o)
  );

  // scoreboard state
  int            checks = 0;
  int            failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            done_log[$];
  int            stray_le = 0;
  logic [DW-1:0] words [0:255];

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (ker_wr_en_o) obs_q.push_back({layer_end_o, ker_wr_addr_o, ker_wr_data_o});
    else if (layer_end_o) stray_le++;
    if (done_o) done_log.push_back(obs_q.size());
  end

  // consumer model: release a loaded half rel_delay cycles after seeing it
  logic rel_en = 1'b0;
  int   rel_delay = 2;
  int   rel_wait = 0;
  always @(posedge clk) begin
    #1;
    rel_auto = 1'b0;
    if (rel_en && ker_avail_o != 2'b00) begin
      if (rel_wait >= rel_delay) begin
        rel_auto = 1'b1;
        rel_wait = 0;
      end else begin
        rel_wait++;
      end
    end else begin
      rel_wait = 0;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic build_exp(input vec_t v);
    int a;
    logic le;
    exp_q.delete();
    for (int k = 0; k < v.exp_writes; k++) begin
      words[k] = {$urandom, $urandom};
      a  = v.rep ? (k % (int'(v.rep_lim) + 1)) : k;
      le = ((k % (int'(v.layr_lim) + 1)) == int'(v.layr_lim));
      exp_q.push_back({le, AW'(a), words[k]});
    end
  endtask

  // returns at posedge+#1 with the fire started and config ports scrambled
  task automatic start_fire(input vec_t v);
    repeat_en_i     = v.rep;
    fire_addr_lim_i = v.fire_lim;
    layr_addr_lim_i = v.layr_lim;
    rep_addr_lim_i  = v.rep_lim;
    tot_rep_ker_i   = v.tot;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat_en_i     = ~v.rep;
    fire_addr_lim_i = AW'($urandom_range(4095));
    layr_addr_lim_i = 6'($urandom_range(63));
    rep_addr_lim_i  = 7'($urandom_range(127));
    tot_rep_ker_i   = CW'($urandom_range(65535));
  endtask

  task automatic stream(input int from, input int to, input int pct, input logic glitch);
    int   idx;
    int   t;
    logic glitched;
    idx = from;
    t = 0;
    glitched = 1'b0;
    while (idx < to && t < 4000) begin
      din_valid_i = ($urandom_range(99) < pct);
      din_i = din_valid_i ? words[idx] : {$urandom, $urandom};
      start_i = glitch && !glitched && (idx == (from + to) / 2);
      if (start_i) begin
        glitched = 1'b1;
        repeat_en_i = ~repeat_en_i;
      end
      @(negedge clk);
      if (din_valid_i && din_ready_o) idx++;
      @(posedge clk); #1;
      t++;
    end
    din_valid_i = 1'b0;
    start_i = 1'b0;
    check("stream_progress", idx, to);
  endtask

  task automatic xfer_word(input logic [DW-1:0] d, input logic rel);
    int t;
    t = 0;
    @(posedge clk); #1;
    din_valid_i = 1'b1;
    din_i = d;
    rel_man = rel;
    @(negedge clk);
    while (!din_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("xfer_timeout", t, 0);
    @(posedge clk); #1;
    din_valid_i = 1'b0;
    rel_man = 1'b0;
  endtask

  task automatic finish_fire(input int base, input int dbase, input int n, input int exp_le,
                             input logic rep);
    int t;
    int got;
    int le;
    logic [EW-1:0] e;
    t = 0;
    while (done_log.size() == dbase && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_log.size() - dbase, 1);
    if (done_log.size() > dbase) check("done_after_last_write", done_log[dbase], base + n);
    check("busy_after_done", busy_o, 1'b0);
    if (rep) begin
      t = 0;
      while (ker_avail_o != 2'b00 && t < 300) begin
        @(posedge clk);
        t++;
      end
      #1;
      check("avail_drained", ker_avail_o, 2'b00);
    end
    rel_en = 1'b0;
    got = obs_q.size() - base;
    check("wr_count", got, n);
    le = 0;
    for (int i = 0; i < got && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      check("wr_word", obs_q[base + i], e);
      le += int'(obs_q[base + i][EW-1]);
    end
    check("layer_ends", le, exp_le);
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int base;
    int dbase;
    base  = obs_q.size();
    dbase = done_log.size();
    build_exp(v);
    rel_delay = v.rel_delay;
    rel_en = v.rep;
    start_fire(v);
    stream(0, v.exp_writes, v.valid_pct, v.glitch);
    finish_fire(base, dbase, v.exp_writes, v.exp_le, v.rep);
  endtask

  vec_t vecs[7];
  vec_t h;
  int   base;
  int   dbase;

  initial begin
    // repeat-mode rows total an even number of kernels, so both ping-pong
    // pointers are back on half 0 for the hand-written sequences below
    //         rep   fire    layr   rep    tot    pct rel glitch writes le
    vecs[0] = '{1'b0, 12'd15, 6'd3, 7'd0, 16'd0, 100, 0, 1'b0, 16, 4};
    vecs[1] = '{1'b1, 12'd0,  6'd3, 7'd7, 16'd4, 100, 2, 1'b0, 16, 4};
    vecs[2] = '{1'b0, 12'd9,  6'd4, 7'd0, 16'd0,  50, 0, 1'b1, 10, 2};
    vecs[3] = '{1'b1, 12'd0,  6'd1, 7'd3, 16'd5,  70, 0, 1'b0, 10, 5};
    vecs[4] = '{1'b0, 12'd0,  6'd0, 7'd0, 16'd0, 100, 0, 1'b0,  1, 1};
    vecs[5] = '{1'b1, 12'd0,  6'd0, 7'd1, 16'd1, 100, 3, 1'b0,  1, 1};
    vecs[6] = '{1'b0, 12'd20, 6'd5, 7'd0, 16'd0,  60, 0, 1'b1, 21, 3};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", ker_wr_en_o, 1'b0);
    check("rst_ready", din_ready_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_avail", ker_avail_o, 2'b00);
    check("rst_state", dbg_state_o, ST_IDLE);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // repeat mode, consumer silent: both halves fill, writer stalls
    h = '{1'b1, 12'd0, 6'd3, 7'd7, 16'd4, 100, 0, 1'b0, 16, 4};
    base  = obs_q.size();
    dbase = done_log.size();
    build_exp(h);
    start_fire(h);
    for (int k = 0; k < 8; k++) xfer_word(words[k], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("norel_avail", ker_avail_o, 2'b11);
    check("norel_ready", din_ready_o, 1'b0);
    din_valid_i = 1'b1;
    din_i = words[8];
    repeat (5) @(posedge clk);
    #1;
    check("norel_no_write", obs_q.size() - base, 8);
    rel_delay = 0;
    rel_en = 1'b1;
    stream(8, 16, 100, 1'b0);
    finish_fire(base, dbase, 16, 4, 1'b1);

    // set of half 1 and release of half 0 on the same edge
    base  = obs_q.size();
    dbase = done_log.size();
    build_exp(h);
    start_fire(h);
    for (int k = 0; k < 4; k++) xfer_word(words[k], 1'b0);
    check("sc_avail_first", ker_avail_o, 2'b01);
    for (int k = 4; k < 7; k++) xfer_word(words[k], 1'b0);
    xfer_word(words[7], 1'b1);
    check("sc_avail_same_cycle", ker_avail_o, 2'b10);
    rel_delay = 1;
    rel_en = 1'b1;
    stream(8, 16, 100, 1'b0);
    finish_fire(base, dbase, 16, 4, 1'b1);

    // reset in the middle of a LOAD fire, right after address 5
    h = '{1'b0, 12'd15, 6'd3, 7'd0, 16'd0, 100, 0, 1'b0, 6, 1};
    base  = obs_q.size();
    dbase = done_log.size();
    build_exp(h);
    start_fire(h);
    for (int k = 0; k < 6; k++) xfer_word(words[k], 1'b0);
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_wr_en", ker_wr_en_o, 1'b0);
    check("mid_rst_addr", ker_wr_addr_o, '0);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_ready", din_ready_o, 1'b0);
    check("mid_rst_state", dbg_state_o, ST_IDLE);
    @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_log.size() - dbase, 0);
    check("mid_rst_wr_count", obs_q.size() - base, 6);
    exp_q.delete();

    // fresh fire after the abort must start at address 0
    run_vec(vecs[0]);

    check("stray_layer_end", stray_le, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
